seq_cska_adder: RTL and testbench
=================================

SEQ_CSKA_ADDER -- requirements
Module: seq_cska_adder

Interface
REQ-001 Parameter WIDTH, default 19: operand width in bits, legal range 2..64.
REQ-002 Parameter BLK, default 4: carry-skip block size in bits, legal range 1..WIDTH; block count NBLK = ceil(WIDTH/BLK).
REQ-003 CLK  input  1  the single clock; all state updates on its rising edge.
REQ-004 RSTn  input  1  reset, asynchronous and active-low.
REQ-005 IN_VALID  input  1  operand set offered.
REQ-006 IN_READY  output  1  block can accept an operand set.
REQ-007 X  input  WIDTH  operand 1, unsigned or two's complement.
REQ-008 Y  input  WIDTH  operand 2.
REQ-009 CIN  input  1  carry-in when SUB=0; borrow-in when SUB=1.
REQ-010 SUB  input  1  0 = add, 1 = subtract.
REQ-011 OUT_VALID  output  1  result available.
REQ-012 OUT_READY  input  1  consumer takes the result.
REQ-013 S  output  WIDTH+1  result; S[WIDTH] is the raw carry-out.
REQ-014 OVF  output  1  two's-complement overflow of the WIDTH-bit result.
REQ-015 SKIP_CNT  output  clog2(NBLK+1)  number of blocks whose carry took the skip path.

Function
REQ-016 The block SHALL have the states IDLE, BUSY and DONE, and IN_READY SHALL be 1 only in IDLE.
REQ-017 IDLE: on IN_VALID&IN_READY, capture X, Y^{WIDTH{SUB}} and the effective carry c0 = CIN^SUB; clear the block index, partial sum and SKIP_CNT; go to BUSY.
REQ-018 BUSY: per cycle, process block k (bits k*BLK .. min((k+1)*BLK, WIDTH)-1) with ripple carry from the registered carry; write those sum bits; register the block carry-out.
REQ-019 Block carry-out = ripple carry-out OR (all P bits of block = 1 AND block carry-in), where P = X ^ Yeff per bit.
REQ-020 SKIP_CNT SHALL increment when a block's P bits are all 1; for a partial last block, only real bits are checked.
REQ-021 After block NBLK-1 the block SHALL enter DONE, so OUT_VALID rises exactly NBLK cycles after the accept edge.
REQ-022 On DONE entry, S[WIDTH] = final carry-out and OVF = carry into bit WIDTH-1 XOR carry-out.
REQ-023 DONE: S, OVF and SKIP_CNT SHALL hold stable while OUT_VALID=1 and OUT_READY=0.
REQ-024 On OUT_VALID&OUT_READY the block SHALL go to IDLE; a new accept is possible no earlier than the next cycle.
REQ-025 IN_VALID while BUSY or DONE SHALL be ignored; operand inputs are sampled only on the accept edge.
REQ-026 Arithmetic: S = X + Yeff + c0 modulo 2^(WIDTH+1); SUB=1, CIN=0 gives X-Y; SUB=1, CIN=1 gives X-Y-1.
REQ-027 BLK = WIDTH SHALL yield NBLK = 1 and a latency of 1 cycle; BLK = 1 SHALL yield a latency of WIDTH cycles.

Reset
REQ-028 RSTn low SHALL, without waiting for CLK, force state IDLE, IN_READY=1, OUT_VALID=0, S=0, OVF=0, SKIP_CNT=0, and clear the block index and carry register.
REQ-029 Reset asserted in BUSY or DONE SHALL discard the operation in progress; no OUT_VALID results from it after release.

Verification (WIDTH=19, BLK=4, NBLK=5)
REQ-030 X=0x7FFFF, Y=0x00001, CIN=0, SUB=0 -> after 5 cycles OUT_VALID=1, S=0x80000, OVF=0, SKIP_CNT=4.
REQ-031 X=0x3FFFF, Y=0x00001, CIN=0, SUB=0 -> S=0x40000, OVF=1, SKIP_CNT=3.
REQ-032 X=5, Y=7, CIN=0, SUB=1 -> S=0x7FFFE (S[19]=0, borrow), OVF=0; repeat with CIN=1 -> S=0x7FFFD.
REQ-033 Hold OUT_READY=0 for 3 cycles after OUT_VALID -> S, OVF and SKIP_CNT unchanged, IN_READY=0 throughout; OUT_READY=1 -> IDLE next cycle, IN_READY=1.
REQ-034 Pulse RSTn low in the 3rd BUSY cycle -> all outputs read their reset values at once; after release IN_READY=1 and OUT_VALID stays 0 until a new accept.
REQ-035 Random regression over parameter sets (WIDTH, BLK) in {(19,4), (19,19), (8,1), (64,7)}: S and OVF match a reference X+Yeff+c0, and latency equals NBLK.

Source files
------------

// File: rtl/seq_cska_adder.sv
// Sequential carry-skip adder/subtractor: processes one BLK-bit block per cycle,
// reporting carry-out, signed overflow and how many blocks took the skip path.
//
// state | meaning
// IDLE  | ready for a new operand set
// BUSY  | rippling one block per cycle
// DONE  | result held until consumer takes it
module seq_cska_adder #(
  parameter int WIDTH = 19,
  parameter int BLK   = 4,
  localparam int NBLK = (WIDTH + BLK - 1) / BLK,
  localparam int CW   = $clog2(NBLK + 1)
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             CIN,
  input  logic             SUB,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH:0]   S,
  output logic             OVF,
  output logic [CW-1:0]    SKIP_CNT
);

  localparam int IW = (NBLK > 1) ? $clog2(NBLK) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NBLK - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] x_r;
  logic [WIDTH-1:0] y_r;
  logic             carry_r;
  logic [IW-1:0]    blk_idx;
  logic [WIDTH:0]   s_r;
  logic             ovf_r;
  logic [CW-1:0]    skip_r;

  int               base;
  logic [BLK-1:0]   x_blk;
  logic [BLK-1:0]   y_blk;
  logic [BLK-1:0]   sum_blk;
  logic [WIDTH:0]   s_mask;
  logic [WIDTH:0]   s_next;
  logic             c;
  logic             p;
  logic             g;
  logic             all_p;
  logic             c_msb;
  logic             blk_cout;
  logic             last_blk;

  // Bits past WIDTH-1 in a partial last block are excluded from both the sum and the skip test.
  always_comb begin
    base     = int'(blk_idx) * BLK;
    x_blk    = BLK'(x_r >> base);
    y_blk    = BLK'(y_r >> base);
    sum_blk  = '0;
    c        = carry_r;
    p        = 1'b0;
    g        = 1'b0;
    all_p    = 1'b1;
    c_msb    = 1'b0;
    last_blk = (blk_idx == LAST_IDX);
    for (int i = 0; i < BLK; i++) begin
      if (base + i < WIDTH) begin
        p          = x_blk[i] ^ y_blk[i];
        g          = x_blk[i] & y_blk[i];
        sum_blk[i] = p ^ c;
        if (base + i == WIDTH - 1) c_msb = c;
        c          = g | (p & c);
        all_p      = all_p & p;
      end
    end
    blk_cout = c | (all_p & carry_r);
    s_mask   = (WIDTH + 1)'({BLK{1'b1}}) << base;
    s_next   = (s_r & ~s_mask) | ((WIDTH + 1)'(sum_blk) << base);
    if (last_blk) s_next[WIDTH] = blk_cout;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state   <= IDLE;
      x_r     <= '0;
      y_r     <= '0;
      carry_r <= 1'b0;
      blk_idx <= '0;
      s_r     <= '0;
      ovf_r   <= 1'b0;
      skip_r  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (IN_VALID) begin
            x_r     <= X;
            y_r     <= Y ^ {WIDTH{SUB}};
            carry_r <= CIN ^ SUB;
            blk_idx <= '0;
            s_r     <= '0;
            ovf_r   <= 1'b0;
            skip_r  <= '0;
            state   <= BUSY;
          end
        end
        BUSY: begin
          s_r     <= s_next;
          carry_r <= blk_cout;
          skip_r  <= skip_r + CW'(all_p);
          if (last_blk) begin
            ovf_r <= c_msb ^ blk_cout;
            state <= DONE;
          end else begin
            blk_idx <= blk_idx + 1'b1;
          end
        end
        DONE: begin
          if (OUT_READY) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign IN_READY  = (state == IDLE);
  assign OUT_VALID = (state == DONE);
  assign S         = s_r;
  assign OVF       = ovf_r;
  assign SKIP_CNT  = skip_r;

endmodule

// File: tb/tb_seq_cska_adder.sv
// Self-checking bench for seq_cska_adder: four parameterisations checked against
// an arithmetic reference model, plus directed, hold and reset scenarios.
module tb_seq_cska_adder;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [3:0]  iv;
  logic [63:0] x_drv, y_drv;
  logic        cin, sub, out_ready;
  logic [3:0]  ir, ov, ovf;
  logic [19:0] s0, s1;
  logic [8:0]  s2;
  logic [64:0] s3;
  logic [2:0]  k0;
  logic [0:0]  k1;
  logic [3:0]  k2, k3;

  int checks = 0;
  int errors = 0;
  int ws [4] = '{19, 19, 8, 64};
  int bs [4] = '{4, 19, 1, 7};

  seq_cska_adder #(.WIDTH(19), .BLK(4)) u0 (
    .CLK(clk), .RSTn(rst_n), .IN_VALID(iv[0]), .IN_READY(ir[0]), .X(x_drv[18:0]), .Y(y_drv[18:0]),
    .CIN(cin), .SUB(sub), .OUT_VALID(ov[0]), .OUT_READY(out_ready), .S(s0), .OVF(ovf[0]), .SKIP_CNT(k0));
  seq_cska_adder #(.WIDTH(19), .BLK(19)) u1 (
    .CLK(clk), .RSTn(rst_n), .IN_VALID(iv[1]), .IN_READY(ir[1]), .X(x_drv[18:0]), .Y(y_drv[18:0]),
    .CIN(cin), .SUB(sub), .OUT_VALID(ov[1]), .OUT_READY(out_ready), .S(s1), .OVF(ovf[1]), .SKIP_CNT(k1));
  seq_cska_adder #(.WIDTH(8), .BLK(1)) u2 (
    .CLK(clk), .RSTn(rst_n), .IN_VALID(iv[2]), .IN_READY(ir[2]), .X(x_drv[7:0]), .Y(y_drv[7:0]),
    .CIN(cin), .SUB(sub), .OUT_VALID(ov[2]), .OUT_READY(out_ready), .S(s2), .OVF(ovf[2]), .SKIP_CNT(k2));
  seq_cska_adder #(.WIDTH(64), .BLK(7)) u3 (
    .CLK(clk), .RSTn(rst_n), .IN_VALID(iv[3]), .IN_READY(ir[3]), .X(x_drv), .Y(y_drv),
    .CIN(cin), .SUB(sub), .OUT_VALID(ov[3]), .OUT_READY(out_ready), .S(s3), .OVF(ovf[3]), .SKIP_CNT(k3));

  logic [1:0]  sel;
  logic        in_ready_sel, out_valid_sel, ovf_sel;
  logic [64:0] s_sel;
  logic [3:0]  skip_sel;

  always_comb begin
    in_ready_sel  = ir[sel];
    out_valid_sel = ov[sel];
    ovf_sel       = ovf[sel];
    s_sel         = '0;
    skip_sel      = '0;
    case (sel)
      2'd0: begin s_sel = {45'd0, s0}; skip_sel = {1'b0, k0}; end
      2'd1: begin s_sel = {45'd0, s1}; skip_sel = {3'b0, k1}; end
      2'd2: begin s_sel = {56'd0, s2}; skip_sel = k2; end
      default: begin s_sel = s3; skip_sel = k3; end
    endcase
  end

  // Reference: plain wide arithmetic, signed overflow from operand/result signs.
  task automatic model(input int w, input int b, input logic [63:0] x, input logic [63:0] y,
                       input logic ci, input logic su, output logic [64:0] s_exp,
                       output logic ovf_exp, output int skip_exp, output int lat_exp);
    logic [63:0] mask, xm, ym;
    logic [64:0] full;
    int nblk;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    xm = x & mask;
    ym = (su ? ~y : y) & mask;
    full = {1'b0, xm} + {1'b0, ym} + {64'd0, ci ^ su};
    s_exp = (w == 64) ? full : (full & ((65'd1 << (w + 1)) - 65'd1));
    ovf_exp = (xm[w-1] == ym[w-1]) && (full[w-1] != xm[w-1]);
    nblk = (w + b - 1) / b;
    skip_exp = 0;
    for (int k = 0; k < nblk; k++) begin
      bit allp;
      allp = 1'b1;
      for (int i = k * b; i < (k + 1) * b && i < w; i++)
        if ((xm[i] ^ ym[i]) == 1'b0) allp = 1'b0;
      if (allp) skip_exp++;
    end
    lat_exp = nblk;
  endtask

  // Offers one operand set to instance idx and waits (bounded) for OUT_VALID.
  task automatic run_op(input logic [1:0] idx, input logic [63:0] x, input logic [63:0] y,
                        input logic ci, input logic su, output int lat);
    sel = idx;
    @(negedge clk);
    x_drv = x; y_drv = y; cin = ci; sub = su;
    checks++;
    if (in_ready_sel !== 1'b1) begin
      errors++;
      $display("FAIL in_ready_idle inst %0d: got %b want 1", idx, in_ready_sel);
    end
    iv[idx] = 1'b1;
    @(posedge clk);
    #1;
    iv = '0;
    x_drv = ~x; y_drv = ~y; cin = ~ci;
    lat = 0;
    while (out_valid_sel !== 1'b1 && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checks++;
    if (in_ready_sel !== 1'b1 || out_valid_sel !== 1'b0) begin
      errors++;
      $display("FAIL consume_idle: in_ready=%b out_valid=%b want 1/0", in_ready_sel, out_valid_sel);
    end
  endtask

  task automatic test_reset();
    sel = 2'd0;
    rst_n = 1'b0;
    #3;
    checks++;
    if (in_ready_sel !== 1'b1 || out_valid_sel !== 1'b0 || s_sel !== 65'd0 || ovf_sel !== 1'b0 || skip_sel !== 4'd0) begin
      errors++;
      $display("FAIL reset_values: ir=%b ov=%b s=%h ovf=%b skip=%0d want 1 0 0 0 0",
               in_ready_sel, out_valid_sel, s_sel, ovf_sel, skip_sel);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [63:0] tx [4] = '{64'h7FFFF, 64'h3FFFF, 64'd5, 64'd5};
    logic [63:0] ty [4] = '{64'h1, 64'h1, 64'd7, 64'd7};
    logic        tc [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic        tsb [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [64:0] ts [4] = '{65'h80000, 65'h40000, 65'h7FFFE, 65'h7FFFD};
    logic        to [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    int          tk [4] = '{4, 3, 4, 4};
    int lat;
    for (int n = 0; n < 4; n++) begin
      run_op(2'd0, tx[n], ty[n], tc[n], tsb[n], lat);
      checks++;
      if (lat != 5) begin
        errors++;
        $display("FAIL directed_latency #%0d: got %0d want 5", n, lat);
      end
      checks++;
      if (s_sel !== ts[n] || ovf_sel !== to[n] || skip_sel !== 4'(tk[n])) begin
        errors++;
        $display("FAIL directed_result #%0d: s=%h ovf=%b skip=%0d want s=%h ovf=%b skip=%0d",
                 n, s_sel, ovf_sel, skip_sel, ts[n], to[n], tk[n]);
      end
      consume();
    end
  endtask

  task automatic test_hold();
    logic [64:0] se; logic oe; int ke, le, lat;
    model(19, 4, 64'h12345, 64'h6789A, 1'b1, 1'b0, se, oe, ke, le);
    run_op(2'd0, 64'h12345, 64'h6789A, 1'b1, 1'b0, lat);
    for (int n = 0; n < 3; n++) begin
      x_drv = 64'h55555; y_drv = 64'h2AAAA; iv[0] = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (s_sel !== se || ovf_sel !== oe || skip_sel !== 4'(ke) || in_ready_sel !== 1'b0 || out_valid_sel !== 1'b1) begin
        errors++;
        $display("FAIL hold_cycle %0d: s=%h ovf=%b skip=%0d ir=%b ov=%b want s=%h ovf=%b skip=%0d ir=0 ov=1",
                 n, s_sel, ovf_sel, skip_sel, in_ready_sel, out_valid_sel, se, oe, ke);
      end
    end
    iv = '0;
    consume();
  endtask

  task automatic test_reset_busy();
    sel = 2'd0;
    @(negedge clk);
    x_drv = 64'h7FFFF; y_drv = 64'h1; cin = 1'b0; sub = 1'b0;
    iv[0] = 1'b1;
    @(posedge clk);
    #1;
    iv = '0;
    repeat (2) begin @(posedge clk); #1; end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready_sel !== 1'b1 || out_valid_sel !== 1'b0 || s_sel !== 65'd0 || ovf_sel !== 1'b0 || skip_sel !== 4'd0) begin
      errors++;
      $display("FAIL reset_in_busy: ir=%b ov=%b s=%h ovf=%b skip=%0d want 1 0 0 0 0",
               in_ready_sel, out_valid_sel, s_sel, ovf_sel, skip_sel);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 8; n++) begin
      @(posedge clk);
      #1;
      checks++;
      if (out_valid_sel !== 1'b0 || in_ready_sel !== 1'b1) begin
        errors++;
        $display("FAIL reset_discard cycle %0d: ov=%b ir=%b want 0 1", n, out_valid_sel, in_ready_sel);
      end
    end
  endtask

  task automatic test_random();
    logic [63:0] x, y; logic ci, su; logic [64:0] se; logic oe; int ke, le, lat, mode;
    for (int idx = 0; idx < 4; idx++) begin
      for (int n = 0; n < 30; n++) begin
        x = {$urandom, $urandom};
        y = {$urandom, $urandom};
        ci = 1'($urandom_range(0, 1));
        su = 1'($urandom_range(0, 1));
        mode = $urandom_range(0, 3);
        if (mode == 0) y = su ? x : ~x;
        else if (mode == 1) y = 64'd0;
        model(ws[idx], bs[idx], x, y, ci, su, se, oe, ke, le);
        run_op(2'(idx), x, y, ci, su, lat);
        checks++;
        if (lat != le) begin
          errors++;
          $display("FAIL random_latency w=%0d b=%0d: got %0d want %0d", ws[idx], bs[idx], lat, le);
        end
        checks++;
        if (s_sel !== se || ovf_sel !== oe || skip_sel !== 4'(ke)) begin
          errors++;
          $display("FAIL random_result w=%0d b=%0d x=%h y=%h ci=%b sub=%b: s=%h ovf=%b skip=%0d want s=%h ovf=%b skip=%0d",
                   ws[idx], bs[idx], x, y, ci, su, s_sel, ovf_sel, skip_sel, se, oe, ke);
        end
        consume();
      end
    end
  endtask

  initial begin
    iv = '0; x_drv = '0; y_drv = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b0; sel = 2'd0;
    test_reset();
    test_directed();
    test_hold();
    test_reset_busy();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
